// File: rtl/e203_ifu_rfrd_arb_if.sv
// Handshake bundle between the BPU/debug requesters, the arbiter and the shared regfile read port.
interface e203_ifu_rfrd_arb_if #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
);
    logic               bpu_rd_req;
    logic [RFIDX_W-1:0] bpu_rd_idx;
    logic               bpu_rd_gnt;
    logic               bpu_rsp_valid;
    logic [XLEN-1:0]    bpu_rsp_data;
    logic               bpu_flush;

    logic               dbg_rd_req;
    logic [RFIDX_W-1:0] dbg_rd_idx;
    logic               dbg_rsp_ready;
    logic               dbg_rd_gnt;
    logic               dbg_rsp_valid;
    logic [XLEN-1:0]    dbg_rsp_data;

    logic               rf_rd_ena;
    logic [RFIDX_W-1:0] rf_rd_idx;
    logic [XLEN-1:0]    rf_rd_data;

    // Arbiter side
    modport slave (
        input  bpu_rd_req, bpu_rd_idx, bpu_flush,
        input  dbg_rd_req, dbg_rd_idx, dbg_rsp_ready,
        input  rf_rd_data,
        output bpu_rd_gnt, bpu_rsp_valid, bpu_rsp_data,
        output dbg_rd_gnt, dbg_rsp_valid, dbg_rsp_data,
        output rf_rd_ena, rf_rd_idx
    );

    // Requester / regfile side
    modport master (
        output bpu_rd_req, bpu_rd_idx, bpu_flush,
        output dbg_rd_req, dbg_rd_idx, dbg_rsp_ready,
        output rf_rd_data,
        input  bpu_rd_gnt, bpu_rsp_valid, bpu_rsp_data,
        input  dbg_rd_gnt, dbg_rsp_valid, dbg_rsp_data,
        input  rf_rd_ena, rf_rd_idx
    );
endinterface

// File: rtl/e203_ifu_rfrd_arb.sv
// Arbitrates the single regfile read port between BPU JALR-rs1 reads and debug abstract reads.
// Define E203_RFRD_ARB_RR_EN for round-robin on simultaneous requests; otherwise BPU has fixed priority.
module e203_ifu_rfrd_arb #(
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5
) (
    input logic                 clk,
    input logic                 rst_n,
    e203_ifu_rfrd_arb_if.slave  rfrd
);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_RSP} state_e;
    typedef enum logic {OWN_DBG = 1'b0, OWN_BPU = 1'b1} owner_e;

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [RFIDX_W-1:0] idx_q, idx_d;
    logic [XLEN-1:0]    data_q, data_d;

    logic               bpu_gnt, dbg_gnt, rd_ena;
    logic [RFIDX_W-1:0] rd_idx;
    logic               bpu_vld, dbg_vld;
    logic               bpu_req_ok, pick_bpu;

    // A flushed BPU request is not eligible even in IDLE
    assign bpu_req_ok = rfrd.bpu_rd_req & ~rfrd.bpu_flush;

`ifdef E203_RFRD_ARB_RR_EN
    owner_e last_q, last_d;
    assign pick_bpu = bpu_req_ok & (~rfrd.dbg_rd_req | (last_q == OWN_DBG));
`else
    assign pick_bpu = bpu_req_ok;
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        idx_d   = idx_q;
        data_d  = data_q;
        bpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        rd_ena  = 1'b0;
        rd_idx  = '0;
        bpu_vld = 1'b0;
        dbg_vld = 1'b0;
`ifdef E203_RFRD_ARB_RR_EN
        last_d  = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_bpu) begin
                    bpu_gnt = 1'b1;
                    rd_ena  = 1'b1;
                    rd_idx  = rfrd.bpu_rd_idx;
                    owner_d = OWN_BPU;
                    idx_d   = rfrd.bpu_rd_idx;
                    state_d = ST_RD;
`ifdef E203_RFRD_ARB_RR_EN
                    last_d  = OWN_BPU;
`endif
                end else if (rfrd.dbg_rd_req) begin
                    dbg_gnt = 1'b1;
                    rd_ena  = 1'b1;
                    rd_idx  = rfrd.dbg_rd_idx;
                    owner_d = OWN_DBG;
                    idx_d   = rfrd.dbg_rd_idx;
                    state_d = ST_RD;
`ifdef E203_RFRD_ARB_RR_EN
                    last_d  = OWN_DBG;
`endif
                end
            end
            ST_RD: begin
                if ((owner_q == OWN_BPU) && rfrd.bpu_flush) begin
                    state_d = ST_IDLE;
                end else begin
                    // x0 reads as zero regardless of what the regfile returns
                    data_d  = (idx_q == '0) ? '0 : rfrd.rf_rd_data;
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (owner_q == OWN_BPU) begin
                    bpu_vld = ~rfrd.bpu_flush;
                    state_d = ST_IDLE;
                end else begin
                    dbg_vld = 1'b1;
                    if (rfrd.dbg_rsp_ready) state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_DBG;
            idx_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
        end
    end

`ifdef E203_RFRD_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_q <= OWN_DBG;
        else        last_q <= last_d;
    end
`endif

    // Grants are combinational from the request, so hold them off while reset is asserted
    assign rfrd.bpu_rd_gnt    = bpu_gnt & rst_n;
    assign rfrd.dbg_rd_gnt    = dbg_gnt & rst_n;
    assign rfrd.rf_rd_ena     = rd_ena & rst_n;
    assign rfrd.rf_rd_idx     = rd_idx & {RFIDX_W{rst_n}};
    assign rfrd.bpu_rsp_valid = bpu_vld;
    assign rfrd.dbg_rsp_valid = dbg_vld;
    assign rfrd.bpu_rsp_data  = bpu_vld ? data_q : '0;
    assign rfrd.dbg_rsp_data  = dbg_vld ? data_q : '0;

endmodule

// File: tb/tb_e203_ifu_rfrd_arb.sv
// Directed bench for the regfile read arbiter: single reads, back-pressure, arbitration, flush and reset.
module tb_e203_ifu_rfrd_arb;

`ifdef E203_RFRD_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   exp_b;
    logic [31:0] rf_q;

    e203_ifu_rfrd_arb_if #(.XLEN(32), .RFIDX_W(5)) rfrd ();

    e203_ifu_rfrd_arb #(.XLEN(32), .RFIDX_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rfrd  (rfrd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Regfile contents: x5 = 0x8000_0100, x0 deliberately nonzero, others {3'b101, idx, 24'h5A3C0F}
    function automatic logic [31:0] rfval(input logic [4:0] i);
        if (i == 5'd5)      return 32'h8000_0100;
        else if (i == 5'd0) return 32'hDEAD_BEEF;
        else                return {3'b101, i, 24'h5A3C0F};
    endfunction

    always @(posedge clk) if (rfrd.rf_rd_ena) rf_q <= rfval(rfrd.rf_rd_idx);
    assign rfrd.rf_rd_data = rf_q;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n              = 1'b0;
        rfrd.bpu_rd_req    = 1'b1;
        rfrd.bpu_rd_idx    = 5'd5;
        rfrd.bpu_flush     = 1'b0;
        rfrd.dbg_rd_req    = 1'b1;
        rfrd.dbg_rd_idx    = 5'd3;
        rfrd.dbg_rsp_ready = 1'b0;
        #2;
        // Reset: everything low even with requests pending
        chk("rst_bgnt", rfrd.bpu_rd_gnt, 0);
        chk("rst_dgnt", rfrd.dbg_rd_gnt, 0);
        chk("rst_rfena", rfrd.rf_rd_ena, 0);
        chk("rst_rfidx", rfrd.rf_rd_idx, 0);
        chk("rst_vld", {rfrd.bpu_rsp_valid, rfrd.dbg_rsp_valid}, 0);
        chk("rst_data", {rfrd.bpu_rsp_data, rfrd.dbg_rsp_data}, 0);
        rfrd.dbg_rd_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1;

        // Single BPU read of x5
        #3;
        chk("b0_gnt", rfrd.bpu_rd_gnt, 1);
        chk("b0_rfena", rfrd.rf_rd_ena, 1);
        chk("b0_rfidx", rfrd.rf_rd_idx, 5);
        chk("b0_dgnt", rfrd.dbg_rd_gnt, 0);
        tick(); rfrd.bpu_rd_req = 1'b0; #3;
        chk("b1_rfena", rfrd.rf_rd_ena, 0);
        chk("b1_gnt", rfrd.bpu_rd_gnt, 0);
        chk("b1_vld", rfrd.bpu_rsp_valid, 0);
        tick(); #3;
        chk("b2_vld", rfrd.bpu_rsp_valid, 1);
        chk("b2_data", rfrd.bpu_rsp_data, 32'h8000_0100);
        chk("b2_dvld", rfrd.dbg_rsp_valid, 0);

        // DBG read of x0 with back-pressure; BPU request waits behind it
        tick(); rfrd.dbg_rd_req = 1'b1; rfrd.dbg_rd_idx = 5'd0; #3;
        chk("d0_bvld", rfrd.bpu_rsp_valid, 0);
        chk("d0_gnt", rfrd.dbg_rd_gnt, 1);
        chk("d0_rfidx", rfrd.rf_rd_idx, 0);
        tick(); rfrd.dbg_rd_req = 1'b0; rfrd.bpu_rd_req = 1'b1; rfrd.bpu_rd_idx = 5'd7; #3;
        chk("d1_bgnt", rfrd.bpu_rd_gnt, 0);
        for (int k = 0; k < 4; k++) begin
            tick(); #3;
            chk("d_hold_vld", rfrd.dbg_rsp_valid, 1);
            chk("d_hold_data", rfrd.dbg_rsp_data, 0);
            chk("d_hold_bgnt", rfrd.bpu_rd_gnt, 0);
        end
        tick(); rfrd.dbg_rsp_ready = 1'b1; #3;
        chk("d_done_vld", rfrd.dbg_rsp_valid, 1);
        chk("d_done_bgnt", rfrd.bpu_rd_gnt, 0);

        // Both requesting continuously: BPU wins first, then alternate (RR) or BPU only (fixed)
        tick(); rfrd.dbg_rd_req = 1'b1; rfrd.dbg_rd_idx = 5'd9; #3;
        chk("arb_dvld_off", rfrd.dbg_rsp_valid, 0);
        chk("arb_rfidx0", rfrd.rf_rd_idx, 7);
        for (int g = 0; g < 4; g++) begin
            exp_b = RR ? (g % 2 == 0) : 1'b1;
            if (g > 0) begin tick(); #3; end
            chk("arb_bgnt", rfrd.bpu_rd_gnt, exp_b);
            chk("arb_dgnt", rfrd.dbg_rd_gnt, !exp_b);
            tick(); #3;
            chk("arb_rd_gnt", {rfrd.bpu_rd_gnt, rfrd.dbg_rd_gnt}, 0);
            tick(); #3;
            chk("arb_rsp_gnt", {rfrd.bpu_rd_gnt, rfrd.dbg_rd_gnt}, 0);
            if (exp_b) begin
                chk("arb_bvld", {rfrd.bpu_rsp_valid, rfrd.dbg_rsp_valid}, 2'b10);
                chk("arb_bdata", rfrd.bpu_rsp_data, 32'hA75A_3C0F);
            end else begin
                chk("arb_dvld", {rfrd.bpu_rsp_valid, rfrd.dbg_rsp_valid}, 2'b01);
                chk("arb_ddata", rfrd.dbg_rsp_data, 32'hA95A_3C0F);
            end
        end
        tick(); rfrd.bpu_rd_req = 1'b0; rfrd.dbg_rd_req = 1'b0; #3;
        chk("arb_idle_gnt", {rfrd.bpu_rd_gnt, rfrd.dbg_rd_gnt}, 0);

        // BPU flushed in RD; pending DBG request granted right after
        tick(); rfrd.bpu_rd_req = 1'b1; rfrd.bpu_rd_idx = 5'd3; rfrd.dbg_rd_req = 1'b1; #3;
        chk("fl_bgnt", rfrd.bpu_rd_gnt, 1);
        tick(); rfrd.bpu_rd_req = 1'b0; rfrd.bpu_flush = 1'b1; #3;
        chk("fl_rd_vld", rfrd.bpu_rsp_valid, 0);
        chk("fl_rd_dgnt", rfrd.dbg_rd_gnt, 0);
        tick(); rfrd.bpu_flush = 1'b0; #3;
        chk("fl_idle_bvld", rfrd.bpu_rsp_valid, 0);
        chk("fl_idle_dgnt", rfrd.dbg_rd_gnt, 1);
        chk("fl_idle_rfidx", rfrd.rf_rd_idx, 9);
        // Flush does not disturb a DBG transaction, and suppresses BPU grant in IDLE
        tick(); rfrd.dbg_rd_req = 1'b0; rfrd.bpu_flush = 1'b1; rfrd.bpu_rd_req = 1'b1; rfrd.bpu_rd_idx = 5'd7; #3;
        chk("fl_drd_bgnt", rfrd.bpu_rd_gnt, 0);
        tick(); #3;
        chk("fl_drsp_vld", rfrd.dbg_rsp_valid, 1);
        chk("fl_drsp_data", rfrd.dbg_rsp_data, 32'hA95A_3C0F);
        tick(); #3;
        chk("fl_idle_sup", {rfrd.bpu_rd_gnt, rfrd.rf_rd_ena}, 0);
        // BPU flushed in RSP
        tick(); rfrd.bpu_flush = 1'b0; #3;
        chk("flr_bgnt", rfrd.bpu_rd_gnt, 1);
        tick(); rfrd.bpu_rd_req = 1'b0; #3;
        tick(); rfrd.bpu_flush = 1'b1; #3;
        chk("flr_rsp_vld", rfrd.bpu_rsp_valid, 0);
        tick(); rfrd.bpu_flush = 1'b0; rfrd.dbg_rd_req = 1'b1; rfrd.dbg_rd_idx = 5'd5;
        rfrd.dbg_rsp_ready = 1'b0; #3;
        chk("flr_after_vld", rfrd.bpu_rsp_valid, 0);
        chk("flr_after_dgnt", rfrd.dbg_rd_gnt, 1);

        // Reset while DBG waits in RSP
        tick(); rfrd.dbg_rd_req = 1'b0; #3;
        tick(); #3;
        chk("rr_wait_vld", rfrd.dbg_rsp_valid, 1);
        chk("rr_wait_data", rfrd.dbg_rsp_data, 32'h8000_0100);
        tick(); rfrd.bpu_rd_req = 1'b1; rfrd.bpu_rd_idx = 5'd5; #3;
        rst_n = 1'b0;
        #2;
        chk("rr_vld", {rfrd.dbg_rsp_valid, rfrd.bpu_rsp_valid}, 0);
        chk("rr_data", rfrd.dbg_rsp_data, 0);
        chk("rr_gnt", {rfrd.bpu_rd_gnt, rfrd.dbg_rd_gnt, rfrd.rf_rd_ena}, 0);
        rfrd.bpu_rd_req = 1'b0;
        tick(); tick();
        rst_n = 1'b1; #3;
        chk("rr_post_vld0", rfrd.dbg_rsp_valid, 0);
        tick(); #3;
        chk("rr_post_vld1", rfrd.dbg_rsp_valid, 0);
        tick(); rfrd.bpu_rd_req = 1'b1; #3;
        chk("rr_new_gnt", rfrd.bpu_rd_gnt, 1);
        tick(); rfrd.bpu_rd_req = 1'b0; #3;
        tick(); #3;
        chk("rr_new_vld", rfrd.bpu_rsp_valid, 1);
        chk("rr_new_data", rfrd.bpu_rsp_data, 32'h8000_0100);
        chk("rr_new_dvld", rfrd.dbg_rsp_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/e203_ifu_rfrd_arb.md
E203_IFU_RFRD_ARB -- requirements
Module: e203_ifu_rfrd_arb

Interface
REQ-001 SHALL have parameter XLEN, 32, register data width.
REQ-002 SHALL have parameter RFIDX_W, 5, register index width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have ports bpu_rd_req / bpu_rd_idx  input  1 / RFIDX_W  BPU JALR-rs1 read request and index.
REQ-006 SHALL have ports bpu_rd_gnt / bpu_rsp_valid / bpu_rsp_data  output  1 / 1 / XLEN  BPU grant, response valid, response data.
REQ-007 SHALL have port bpu_flush  input  1  aborts the BPU transaction (IR cleared / pipeline flush).
REQ-008 SHALL have ports dbg_rd_req / dbg_rd_idx / dbg_rsp_ready  input  1 / RFIDX_W / 1  debug abstract-command read request, index, response ready.
REQ-009 SHALL have ports dbg_rd_gnt / dbg_rsp_valid / dbg_rsp_data  output  1 / 1 / XLEN  debug grant, response valid, response data.
REQ-010 SHALL have ports rf_rd_ena / rf_rd_idx  output  1 / RFIDX_W  shared regfile read port request.
REQ-011 SHALL have port rf_rd_data  input  XLEN  regfile read data, valid the cycle after rf_rd_ena.

Function
REQ-012 SHALL implement FSM states IDLE, RD, RSP; single owner register (BPU or DBG) plus captured index and data.
REQ-013 In IDLE with any request, SHALL assert exactly one combinational grant, drive rf_rd_ena=1 and rf_rd_idx=winner index, latch owner and index, go to RD.
REQ-014 In IDLE with no request, SHALL keep rf_rd_ena=0, gnt=0, remain IDLE.
REQ-015 In RD, SHALL capture rf_rd_data (forced to 0 when latched index is 0) and go to RSP; no grant, rf_rd_ena=0.
REQ-016 In RSP, SHALL assert owner's rsp_valid with captured data; BPU response is consumed unconditionally (BPU always ready) -> IDLE next cycle; DBG response held stable until dbg_rsp_ready=1 -> IDLE.
REQ-017 Grant SHALL NOT be issued in the cycle a response completes; next grant earliest one cycle later (3-cycle minimum per transaction: grant, RD, RSP).
REQ-018 bpu_flush while owner=BPU in RD or RSP SHALL return FSM to IDLE next cycle with bpu_rsp_valid=0 in that cycle; bpu_flush in IDLE SHALL suppress bpu grant that cycle.
REQ-019 bpu_flush SHALL have no effect on a DBG-owned transaction.
REQ-020 Requests are level; a requester SHALL hold req and idx stable until granted; idx sampled only at grant.
REQ-021 Response data SHALL stay stable while rsp_valid=1; non-owner rsp_valid=0 always.

Reset
REQ-022 On rst_n=0 SHALL force state IDLE, owner=DBG, last_owner=DBG, captured data/index=0; all outputs 0 (gnt, rsp_valid, rsp_data, rf_rd_ena, rf_rd_idx).
REQ-023 Reset mid-transaction SHALL drop it silently; no response issued after release.

Configuration
REQ-024 Macro E203_RFRD_ARB_RR_EN defined: on simultaneous requests in IDLE, grant the requester that was not last_owner; last_owner updated at every grant.
REQ-025 Macro undefined: fixed priority, BPU always wins simultaneous requests; last_owner register absent.

Verification
REQ-026 Single BPU read of x5 holding 0x8000_0100 -> gnt cycle 0, rf_rd_ena/idx=5 cycle 0, bpu_rsp_valid=1 data 0x8000_0100 cycle 2, IDLE cycle 3.
REQ-027 DBG read x0 with dbg_rsp_ready low 4 cycles -> dbg_rsp_valid held 4+ cycles, data 0x0, completes on ready.
REQ-028 Both request continuously from reset, RR_EN defined -> grants alternate BPU, DBG, BPU, DBG every 3 cycles; undefined -> BPU only, DBG starves while BPU req=1.
REQ-029 BPU granted, bpu_flush=1 in RD -> no bpu_rsp_valid, IDLE next cycle, pending DBG request granted the following cycle.
REQ-030 DBG in RSP waiting, rst_n pulsed low -> all outputs 0 immediately, no response after release, next request granted normally.
